icache: RTL
===========

// Module: icache
// PURPOSE
// Direct-mapped, one-word-per-line instruction cache between the fetch unit and the ic port of mem_ctrl.
// Hits return in 1 cycle. A miss issues one word read on the mem_ctrl ic handshake, fills the line and returns the word.
// It is the requester (initiator) end of the ic_valid/addr_from_ic/ic_enable/inst_to_ic protocol.
// PARAMETERS
// IDX_W   6   index bits; 2**IDX_W lines of 32 bits each
// ADDR_W  32  address width; tag = pc[ADDR_W-1:IDX_W+2]
// PORTS
// clk        in   1   single clock, all state on posedge
// rst_n      in   1   reset, asynchronous, active-low
// rdy        in   1   global ready; when 0 no register updates (holds everything)
// fe_valid   in   1   fetch request; held with stable fe_pc until fe_done or fe_flush
// fe_pc      in   32  fetch address; bits [1:0] ignored
// fe_flush   in   1   abort the outstanding request (branch redirect)
// fe_done    out  1   1-cycle pulse: fe_inst valid for the current request
// fe_inst    out  32  fetched instruction
// mc_valid   out  1   to mem_ctrl ic_valid; held high for the whole miss
// mc_addr    out  32  to mem_ctrl addr_from_ic; {fe_pc[31:2],2'b00}, stable while mc_valid
// mc_done    in   1   from mem_ctrl ic_enable; 1-cycle pulse, mc_inst valid
// mc_inst    in   32  from mem_ctrl inst_to_ic
// BEHAVIOUR
// - Reset (rst_n=0, async): all valid bits 0; state IDLE; fe_done=0, fe_inst=0, mc_valid=0, mc_addr=0.
// - !rdy: state, arrays, and all outputs hold their values. mc_done is not sampled.
// - States: IDLE, MISS, GAP.
// - IDLE, fe_valid & !fe_flush & !fe_done:
//   - Hit (valid[idx] and tag matches): next edge fe_done=1, fe_inst=data[idx]. Latency 1.
//   - Miss: next edge mc_valid=1, mc_addr latched, state MISS.
//   - fe_done is low in the cycle after a pulse. A request still showing fe_valid in that cycle is treated as new.
// - MISS: hold mc_valid and mc_addr.
//   - On mc_done: write data[idx]=mc_inst, tag[idx], and valid[idx]=1.
//   - Next edge: fe_done=1, fe_inst=mc_inst, mc_valid=0, state GAP.
// - GAP: mc_valid=0 for exactly one full cycle, then IDLE.
//   - This is required so mem_ctrl (which restarts on ic_valid high after ic_enable) returns to idle before a new addr.
//   - Fetch requests are not looked up in GAP.
// - fe_flush (any state, rdy=1): next edge fe_done=0.
//   - In MISS, or IDLE with a miss about to issue: mc_valid=0, state GAP. Dropping ic_valid makes mem_ctrl abort.
// - fe_flush and mc_done in the same cycle: the line IS filled (data is correct for mc_addr); fe_done is suppressed; state GAP.
// - mc_done outside MISS is ignored; no fill.
// - fe_done is never asserted in the same cycle as mc_valid rising.
// - At most one outstanding miss. No write path; arrays are only invalidated by reset.
// - Miss latency is set by mem_ctrl (about 6 cycles); the icache adds 1 cycle before issue and 1 cycle after mc_done.
// STRUCTURE
// - utils.v: `define ICACHE_IDLE/MISS/GAP state codes and the default IDX_W.
// - Sub-module icache_line_store: data+tag arrays with 1 write port and async read, indexed by pc[IDX_W+1:2].
// - Valid bits stay in icache as a flop vector so async reset clears them.
// - Top holds the FSM, compare, and the output registers.
// TESTING (bench uses a behavioural mem_ctrl: ic_enable pulse 6 cycles after ic_valid rise, abort when ic_valid drops)
// 1. Cold miss, pc=0x0000_1004, mem word 0x00c58533
//    -> mc_valid rises 1 cycle after fe_valid, mc_addr=0x1004; fe_done pulse with 0x00c58533 1 cycle after mc_done.
// 2. Repeat pc=0x1004 after GAP -> fe_done next cycle with 0x00c58533, mc_valid stays 0.
// 3. Conflict: pc=0x1104 (same idx, IDX_W=6) -> miss, refill.
//    -> Then pc=0x1004 misses again. Check the tag compare.
// 4. fe_flush 3 cycles into a miss -> mc_valid=0 next edge, no fe_done, valid[idx] unchanged.
//    -> New pc=0x2000 issues mc_addr=0x2000 only after a 1-cycle gap.
// 5. fe_flush coincident with mc_done -> no fe_done; a later fetch of the same pc hits in 1 cycle.
// 6. rdy=0 for 4 cycles mid-miss and during a hit pulse -> all outputs frozen, result unchanged after rdy=1.
//    -> Then assert rst_n=0 mid-miss: outputs 0 immediately; the former hit pc misses afterwards.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry
// and FSM state encoding.
package icache_pkg;

  localparam int ICACHE_IDX_W  = 6;
  localparam int ICACHE_ADDR_W = 32;
  localparam int ICACHE_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_GAP  = 2'd2
  } icache_state_e;

endpackage : icache_pkg

// File: rtl/icache_if.sv
// Fetch-side request/response and mem_ctrl ic-port handshake bundled together.
// slave is the cache's view; master is the view of the surrounding fetch unit and memory.
interface icache_if #(
  parameter int ADDR_W = 32
);

  logic              fe_valid;
  logic [ADDR_W-1:0] fe_pc;
  logic              fe_flush;
  logic              fe_done;
  logic [31:0]       fe_inst;
  logic              mc_valid;
  logic [ADDR_W-1:0] mc_addr;
  logic              mc_done;
  logic [31:0]       mc_inst;

  modport slave (
    input  fe_valid, fe_pc, fe_flush, mc_done, mc_inst,
    output fe_done, fe_inst, mc_valid, mc_addr
  );

  modport master (
    output fe_valid, fe_pc, fe_flush, mc_done, mc_inst,
    input  fe_done, fe_inst, mc_valid, mc_addr
  );

endinterface : icache_if

// File: rtl/icache_line_store.sv
// Data and tag arrays for the cache lines: one synchronous write port and one
// asynchronous read port. Contents are never reset; the valid vector lives in the top.
module icache_line_store #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [TAG_W-1:0] wtag_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [TAG_W-1:0] rtag_o,
  output logic [31:0]      rdata_o
);

  localparam int LINES = 1 << IDX_W;

  logic [31:0]      data_q [LINES];
  logic [TAG_W-1:0] tag_q  [LINES];

  // line fill from a completed memory read
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[waddr_i] <= wdata_i;
      tag_q[waddr_i]  <= wtag_i;
    end
  end

  assign rdata_o = data_q[raddr_i];
  assign rtag_o  = tag_q[raddr_i];

endmodule : icache_line_store

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch unit and
// the mem_ctrl ic port; the cache is the requester on the mem_ctrl handshake.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W  = ICACHE_IDX_W,
  parameter int ADDR_W = ICACHE_ADDR_W
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rdy,
  icache_if.slave  bus
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int LINES = 1 << IDX_W;

  icache_state_e     state_q, state_d;
  logic              fe_done_q, fe_done_d;
  logic [31:0]       fe_inst_q, fe_inst_d;
  logic              mc_valid_q, mc_valid_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic [LINES-1:0]  valid_q;

  logic [IDX_W-1:0]  rd_idx_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [TAG_W-1:0]  rd_tag_s;
  logic [TAG_W-1:0]  wr_tag_s;
  logic [TAG_W-1:0]  st_tag_s;
  logic [31:0]       st_data_s;
  logic              hit_s;
  logic              fill_s;
  logic              we_s;
  logic              unused_s;

  // Lookup uses the live fetch pc; the fill uses the latched miss address so a
  // flush that changes fe_pc cannot corrupt the line being written.
  assign rd_idx_s = bus.fe_pc[IDX_W+1:2];
  assign rd_tag_s = bus.fe_pc[ADDR_W-1:IDX_W+2];
  assign wr_idx_s = mc_addr_q[IDX_W+1:2];
  assign wr_tag_s = mc_addr_q[ADDR_W-1:IDX_W+2];
  assign hit_s    = valid_q[rd_idx_s] & (st_tag_s == rd_tag_s);
  assign we_s     = fill_s & rdy;
  assign unused_s = ^bus.fe_pc[1:0];

  icache_line_store #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (wr_idx_s),
    .wtag_i  (wr_tag_s),
    .wdata_i (bus.mc_inst),
    .raddr_i (rd_idx_s),
    .rtag_o  (st_tag_s),
    .rdata_o (st_data_s)
  );

  // next-state and output-register computation for the IDLE/MISS/GAP controller
  always_comb begin
    state_d    = state_q;
    fe_done_d  = 1'b0;
    fe_inst_d  = fe_inst_q;
    mc_valid_d = mc_valid_q;
    mc_addr_d  = mc_addr_q;
    fill_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // fe_done_q high means this cycle still shows the request just answered
        if (bus.fe_valid && !fe_done_q) begin
          if (bus.fe_flush) begin
            if (!hit_s) begin
              state_d = ST_GAP;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (hit_s) begin
            fe_done_d = 1'b1;
            fe_inst_d = st_data_s;
          end else begin
            mc_valid_d = 1'b1;
            mc_addr_d  = {bus.fe_pc[ADDR_W-1:2], 2'b00};
            state_d    = ST_MISS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MISS: begin
        if (bus.mc_done) begin
          fill_s     = 1'b1;
          mc_valid_d = 1'b0;
          state_d    = ST_GAP;
          if (!bus.fe_flush) begin
            fe_done_d = 1'b1;
            fe_inst_d = bus.mc_inst;
          end else begin
            fe_done_d = 1'b0;
          end
        end else if (bus.fe_flush) begin
          mc_valid_d = 1'b0;
          state_d    = ST_GAP;
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_GAP: begin
        // one full cycle with ic_valid low so mem_ctrl settles before a new address
        mc_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        mc_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // state, output and valid-bit registers; rdy low freezes all of them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fe_done_q  <= 1'b0;
      fe_inst_q  <= 32'd0;
      mc_valid_q <= 1'b0;
      mc_addr_q  <= {ADDR_W{1'b0}};
      valid_q    <= {LINES{1'b0}};
    end else if (rdy) begin
      state_q    <= state_d;
      fe_done_q  <= fe_done_d;
      fe_inst_q  <= fe_inst_d;
      mc_valid_q <= mc_valid_d;
      mc_addr_q  <= mc_addr_d;
      if (fill_s) begin
        valid_q[wr_idx_s] <= 1'b1;
      end
    end
  end

  assign bus.fe_done  = fe_done_q;
  assign bus.fe_inst  = fe_inst_q;
  assign bus.mc_valid = mc_valid_q;
  assign bus.mc_addr  = mc_addr_q;

endmodule : icache
